// File: rtl/invaders_pkg.sv
// ============================================================================
// Module : invaders_pkg
// Brief  : Shared formation geometry defaults, fire-scheduler FSM encoding
//          and the column-randomiser LFSR definition.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package invaders_pkg;

    localparam int DEF_N_COLS  = 11;
    localparam int DEF_N_ROWS  = 5;
    localparam int DEF_N_SLOTS = 3;

    // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0]
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] DEF_LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PICK   = 2'd1,
        ST_SCAN   = 2'd2,
        ST_LAUNCH = 2'd3
    } fire_state_t;

    // One shift of the LFSR: feedback is the XOR of the tapped bits
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fire_lfsr.sv
// ============================================================================
// Module : fire_lfsr
// Brief  : 8-bit Fibonacci LFSR with advance enable; exposes its low bits.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fire_lfsr
    import invaders_pkg::*;
#(
    parameter logic [7:0] SEED  = DEF_LFSR_SEED,
    parameter int         OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance_i,
    output logic [OUT_W-1:0] lfsr_o
);

    logic [7:0] lfsr_q;

    // Shift register state; holds when advance is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (advance_i) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign lfsr_o = lfsr_q[OUT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/invader_fire_scheduler.sv
// ============================================================================
// Module : invader_fire_scheduler
// Brief  : Chooses when the formation fires, the firing column (lowest alive
//          invader found by a cell-per-cycle scan) and the free missile slot,
//          and hands the shot to the missile datapath over valid/ready.
//          Optional feature macro: FIRE_AIMED_EN (alternate shots start the
//          scan at the player's column).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module invader_fire_scheduler
    import invaders_pkg::*;
#(
    parameter int         N_COLS          = DEF_N_COLS,
    parameter int         N_ROWS          = DEF_N_ROWS,
    parameter int         N_SLOTS         = DEF_N_SLOTS,
    parameter int         COOLDOWN_FRAMES = 16,
    parameter logic [7:0] LFSR_SEED       = DEF_LFSR_SEED
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_i,
    input  logic                     enable_i,
    input  logic [N_ROWS*N_COLS-1:0] alive_i,
    input  logic [N_SLOTS-1:0]       slot_busy_i,
`ifdef FIRE_AIMED_EN
    input  logic [3:0]               player_col_i,
`endif
    output logic                     launch_valid_o,
    input  logic                     launch_ready_i,
    output logic [1:0]               launch_slot_o,
    output logic [3:0]               launch_col_o,
    output logic [2:0]               launch_row_o
);

    localparam int         CELL_W      = $clog2(N_ROWS*N_COLS);
    localparam logic [3:0] COLS_4      = 4'(N_COLS);
    localparam logic [3:0] COL_LAST    = 4'(N_COLS-1);
    localparam logic [2:0] ROW_TOP     = 3'(N_ROWS-1);
    localparam logic [7:0] COOL_RELOAD = 8'(COOLDOWN_FRAMES);

    fire_state_t       state_q;
    logic [7:0]        cooldown_q;
    logic [1:0]        slot_q;
    logic [3:0]        col_q;
    logic [2:0]        row_q;
    logic [3:0]        tried_q;
    logic              valid_q;
`ifdef FIRE_AIMED_EN
    logic              aim_q;
`endif

    logic [3:0]        lfsr_nib;
    logic [3:0]        start_col_d;
    logic [1:0]        free_slot_d;
    logic              slot_free_d;
    logic [CELL_W-1:0] cell_idx;

    fire_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (4)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .advance_i (1'b1),
        .lfsr_o    (lfsr_nib)
    );

    assign cell_idx = CELL_W'(row_q) * CELL_W'(N_COLS) + CELL_W'(col_q);

    // Start column: LFSR nibble folded into range, or the clamped player column on aimed turns
    always_comb begin
        start_col_d = (lfsr_nib >= COLS_4) ? (lfsr_nib - COLS_4) : lfsr_nib;
`ifdef FIRE_AIMED_EN
        if (aim_q) begin
            start_col_d = (player_col_i > COL_LAST) ? COL_LAST : player_col_i;
        end
`endif
    end

    // Lowest-index free slot; iterating downwards lets the lowest index win
    always_comb begin
        free_slot_d = '0;
        slot_free_d = 1'b0;
        for (int i = N_SLOTS-1; i >= 0; i--) begin
            if (!slot_busy_i[i]) begin
                free_slot_d = 2'(i);
                slot_free_d = 1'b1;
            end
        end
    end

    // Scheduler FSM with cooldown, scan position and registered launch request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cooldown_q <= COOL_RELOAD;
            slot_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            tried_q    <= '0;
            valid_q    <= 1'b0;
`ifdef FIRE_AIMED_EN
            aim_q      <= 1'b0;
`endif
        end else if (state_q == ST_IDLE) begin
            // Frames only count down while idle, whatever enable says
            if (frame_i && (cooldown_q != 8'd0)) begin
                cooldown_q <= cooldown_q - 8'd1;
            end
            if (enable_i && (cooldown_q == 8'd0) && slot_free_d) begin
                state_q <= ST_PICK;
            end
        end else if (!enable_i) begin
            // Abort: cooldown keeps its value so the next shot is not delayed
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_PICK: begin
                    slot_q  <= free_slot_d;
                    col_q   <= start_col_d;
                    row_q   <= ROW_TOP;
                    tried_q <= '0;
                    state_q <= ST_SCAN;
`ifdef FIRE_AIMED_EN
                    aim_q   <= ~aim_q;
`endif
                end
                ST_SCAN: begin
                    if (alive_i[cell_idx]) begin
                        state_q <= ST_LAUNCH;
                        valid_q <= 1'b1;
                    end else if (row_q != 3'd0) begin
                        row_q <= row_q - 3'd1;
                    end else begin
                        col_q   <= (col_q == COL_LAST) ? 4'd0 : (col_q + 4'd1);
                        row_q   <= ROW_TOP;
                        tried_q <= tried_q + 4'd1;
                        if (tried_q == COL_LAST) begin
                            // Whole formation dead: give up this attempt
                            state_q    <= ST_IDLE;
                            cooldown_q <= COOL_RELOAD;
                        end
                    end
                end
                ST_LAUNCH: begin
                    if (launch_ready_i) begin
                        valid_q    <= 1'b0;
                        state_q    <= ST_IDLE;
                        cooldown_q <= COOL_RELOAD;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign launch_valid_o = valid_q;
    assign launch_slot_o  = slot_q;
    assign launch_col_o   = col_q;
    assign launch_row_o   = row_q;

endmodule

`default_nettype wire

// File: tb/tb_invader_fire_scheduler.sv
// ============================================================================
// Module : tb_invader_fire_scheduler
// Brief  : Directed self-checking bench for invader_fire_scheduler.
//          Aimed-fire checks are compiled in with FIRE_AIMED_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_invader_fire_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame;
    logic        enable;
    logic [54:0] alive;
    logic [2:0]  busy;
    logic        ready;
    logic        valid;
    logic [1:0]  slot;
    logic [3:0]  col;
    logic [2:0]  row;
`ifdef FIRE_AIMED_EN
    logic [3:0]  player_col;
`endif

    int          checks = 0;
    int          errors = 0;
    int          picks  = 0;
    logic [7:0]  lfsr_m;

    invader_fire_scheduler #(
        .N_COLS          (11),
        .N_ROWS          (5),
        .N_SLOTS         (3),
        .COOLDOWN_FRAMES (2),
        .LFSR_SEED       (8'hA5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_i        (frame),
        .enable_i       (enable),
        .alive_i        (alive),
        .slot_busy_i    (busy),
`ifdef FIRE_AIMED_EN
        .player_col_i   (player_col),
`endif
        .launch_valid_o (valid),
        .launch_ready_i (ready),
        .launch_slot_o  (slot),
        .launch_col_o   (col),
        .launch_row_o   (row)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lnext(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [3:0] fold(input logic [7:0] l);
        return (l[3:0] >= 4'd11) ? (l[3:0] - 4'd11) : l[3:0];
    endfunction

    function automatic logic [3:0] clampc(input logic [3:0] c);
        return (c > 4'd10) ? 4'd10 : c;
    endfunction

    // Aimed turn when an odd number of attempts have already been picked
    function automatic bit aimed_turn();
`ifdef FIRE_AIMED_EN
        return (picks % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    // Reference LFSR, free running like the one in the design
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 8'hA5;
        else     lfsr_m <= lnext(lfsr_m);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two frame pulses with enable low: cooldown 2 -> 0
    task automatic cool();
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            frame = 1'b1; tick();
            frame = 1'b0; tick();
        end
    endtask

    // From IDLE with cooldown 0 and enable low: trigger an attempt whose
    // scan starts at 'start', expect valid exactly 3+misses cycles later.
    task automatic launch(input logic [3:0] start, input logic [3:0] pcol, input int misses,
                          input logic [1:0] eslot, input logic [3:0] ecol, input logic [2:0] erow,
                          input string name);
        bit early = 0;
        int guard = 0;
        if (aimed_turn()) begin
`ifdef FIRE_AIMED_EN
            player_col = pcol;
`endif
        end else begin
            while (fold(lnext(lfsr_m)) != start && guard < 300) begin
                tick();
                guard++;
            end
            checks++;
            if (guard >= 300) begin
                errors++;
                $display("FAIL %s_lfsr_wait: start column %0d never reached", name, start);
            end
        end
        enable = 1'b1;
        picks++;
        for (int i = 0; i < 2 + misses; i++) begin
            tick();
            if (valid) early = 1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL %s_early: valid seen before cycle %0d", name, 3 + misses);
        end
        tick();
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b want 1", name, valid); end
        checks++;
        if (slot !== eslot) begin errors++; $display("FAIL %s_slot: got %0d want %0d", name, slot, eslot); end
        checks++;
        if (col !== ecol) begin errors++; $display("FAIL %s_col: got %0d want %0d", name, col, ecol); end
        checks++;
        if (row !== erow) begin errors++; $display("FAIL %s_row: got %0d want %0d", name, row, erow); end
    endtask

    // Enable high, cooldown 2: two frames then a launch 3 cycles after the second
    task automatic frame_launch(input string name);
        logic [3:0] ecol;
        for (int i = 0; i < 2; i++) begin
            frame = 1'b1; tick();
            frame = 1'b0;
            if (i == 0) begin
                for (int j = 0; j < 6; j++) begin
                    tick();
                    checks++;
                    if (valid !== 1'b0) begin errors++; $display("FAIL %s_one_frame: got %b want 0", name, valid); end
                end
            end
        end
`ifdef FIRE_AIMED_EN
        ecol = aimed_turn() ? clampc(player_col) : fold(lnext(lfsr_m));
`else
        ecol = fold(lnext(lfsr_m));
`endif
        picks++;
        tick(); tick();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL %s_early: got %b want 0", name, valid); end
        tick();
        checks++;
        if (valid !== 1'b1 || col !== ecol || row !== 3'd4 || slot !== 2'd0) begin
            errors++;
            $display("FAIL %s_launch: got v=%b c=%0d r=%0d s=%0d want v=1 c=%0d r=4 s=0", name, valid, col, row, slot, ecol);
        end
        tick();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL %s_accept: got %b want 0", name, valid); end
        enable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; frame = 1'b0; enable = 1'b0; alive = '1; busy = 3'b000; ready = 1'b1;
`ifdef FIRE_AIMED_EN
        player_col = 4'd0;
`endif
        tick(); tick();
        checks++;
        if (valid !== 1'b0 || slot !== 2'd0 || col !== 4'd0 || row !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b s=%0d c=%0d r=%0d want all 0", valid, slot, col, row);
        end
        rst = 1'b0;
        // Cooldown starts at 2: no shot without frames
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (valid !== 1'b0) begin errors++; $display("FAIL reset_cooldown: got %b want 0", valid); end
        end
        enable = 1'b0;
    endtask

    task automatic test_first_launch();
        cool();
        launch(4'd3, 4'd3, 0, 2'd0, 4'd3, 3'd4, "first");
        tick();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL first_one_cycle: got %b want 0", valid); end
        // Enable stays high: next shot only after two more frames
        enable = 1'b1;
        frame_launch("reload");
    endtask

    task automatic test_slots();
        cool();
        busy = 3'b011;
        launch(4'd5, 4'd5, 0, 2'd2, 4'd5, 3'd4, "slot2");
        tick();
        cool();
        busy = 3'b101;
        launch(4'd7, 4'd7, 0, 2'd1, 4'd7, 3'd4, "slot1");
        tick();
        cool();
        busy = 3'b111;
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (valid !== 1'b0) begin errors++; $display("FAIL slots_all_busy: got %b want 0", valid); end
        end
        enable = 1'b0;
        busy = 3'b000;
    endtask

    task automatic test_scan_skip();
        alive = '1;
        for (int r = 0; r < 5; r++) begin
            alive[r*11 + 3] = 1'b0;
            if (r != 1) alive[r*11 + 4] = 1'b0;
        end
        launch(4'd3, 4'd3, 8, 2'd0, 4'd4, 3'd1, "skip");
        tick();
        cool();
        alive = '0;
        alive[44] = 1'b1;
        launch(4'd10, 4'd10, 5, 2'd0, 4'd0, 3'd4, "wrap");
        tick();
        cool();
    endtask

    task automatic test_all_dead();
        alive = '0;
        enable = 1'b1;
        picks++;
        for (int i = 0; i < 70; i++) begin
            tick();
            checks++;
            if (valid !== 1'b0) begin errors++; $display("FAIL dead_no_valid: got %b want 0", valid); end
        end
        alive = '1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (valid !== 1'b0) begin errors++; $display("FAIL dead_reloaded: got %b want 0", valid); end
        end
        frame_launch("after_dead");
    endtask

    task automatic test_stall();
        bit bad = 0;
        cool();
        ready = 1'b0;
        launch(4'd6, 4'd6, 0, 2'd0, 4'd6, 3'd4, "stall");
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid !== 1'b1 || slot !== 2'd0 || col !== 4'd6 || row !== 3'd4) bad = 1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: got v=%b s=%0d c=%0d r=%0d want v=1 s=0 c=6 r=4", valid, slot, col, row);
        end
        ready = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", valid); end
        cool();
        ready = 1'b0;
        launch(4'd2, 4'd2, 0, 2'd0, 4'd2, 3'd4, "abort");
        for (int i = 0; i < 9; i++) tick();
        enable = 1'b0;
        tick();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL abort_drop: got %b want 0", valid); end
        // Back in IDLE with cooldown still 0: an immediate retry must launch
        ready = 1'b1;
        launch(4'd8, 4'd8, 0, 2'd0, 4'd8, 3'd4, "retry");
        tick();
        enable = 1'b0;
    endtask

`ifdef FIRE_AIMED_EN
    task automatic test_aimed();
        logic [3:0] pc;
        for (int i = 0; i < 4; i++) begin
            cool();
            pc = (i < 2) ? 4'd7 : 4'd14;
            launch(4'd2, pc, 0, 2'd0, aimed_turn() ? clampc(pc) : 4'd2, 3'd4, "aimed");
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_launch();
        test_slots();
        test_scan_skip();
        test_all_dead();
        test_stall();
`ifdef FIRE_AIMED_EN
        test_aimed();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
